hart_mem_arbiter: RTL and testbench

Two-port to one-port memory arbiter between a hart's instruction-fetch port and its data-memory port, driving a single shared memory bus. It sits directly outside `hart`.
- Fetch and data requests are granted round-robin.
- Each granted request's fields are latched and held on the bus until the memory acknowledges.
- The result returns to the winning requester as a one-cycle ready pulse.
- A watchdog aborts any transaction the memory never acknowledges.

---
 rtl/hart_mem_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_hart_mem_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hart_mem_arbiter.sv
// hart_mem_arbiter
//   Shares one memory bus between a hart's instruction-fetch port and its
//   data port. Requests are granted round-robin. The granted request's fields
//   are latched and held on the bus until the memory acks. The result goes
//   back to the winner as a one-cycle ready pulse. A watchdog aborts
//   transactions that never get an ack.
//
// Ports
//   i_clk, i_rst                   clock (rising), async active-low reset
//   i_IC_DataReq, i_IM_Addr        fetch request / address
//   o_IM_Instr, o_IC_MemReady      fetch result / done pulse
//   i_DM_MemRead, i_DM_Wen         data read / write request (write wins)
//   i_DM_Addr, i_DM_Wd, i_DM_byte_en  data address, write data, lanes
//   o_DM_ReadData, o_DM_data_ready data result / done pulse
//   o_MEM_req/we/addr/wdata/byte_en   shared bus request fields
//   i_MEM_ack, i_MEM_rdata         memory completion / read data
//   o_bus_err, o_bus_err_src       watchdog abort pulse / owner (1 = data)
module hart_mem_arbiter #(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_IC_DataReq,
    input  logic [XLEN-1:0]   i_IM_Addr,
    output logic [XLEN-1:0]   o_IM_Instr,
    output logic              o_IC_MemReady,
    input  logic              i_DM_MemRead,
    input  logic              i_DM_Wen,
    input  logic [XLEN-1:0]   i_DM_Addr,
    input  logic [XLEN-1:0]   i_DM_Wd,
    input  logic [XLEN/8-1:0] i_DM_byte_en,
    output logic [XLEN-1:0]   o_DM_ReadData,
    output logic              o_DM_data_ready,
    output logic              o_MEM_req,
    output logic              o_MEM_we,
    output logic [XLEN-1:0]   o_MEM_addr,
    output logic [XLEN-1:0]   o_MEM_wdata,
    output logic [XLEN/8-1:0] o_MEM_byte_en,
    input  logic              i_MEM_ack,
    input  logic [XLEN-1:0]   i_MEM_rdata,
    output logic              o_bus_err,
    output logic              o_bus_err_src
);
    typedef enum logic [1:0] {IDLE, IBUSY, DBUSY} state_e;

    // Counter hits this value on the last BUSY edge before abort.
    localparam logic [15:0] TLIM = 16'(TIMEOUT_CYCLES - 1);

    state_e              state_q, state_d;
    logic                last_q, last_d;           // 1 = data granted last
    logic [15:0]         cnt_q, cnt_d;
    logic                req_q, req_d, we_q, we_d;
    logic [XLEN-1:0]     addr_q, addr_d, wdata_q, wdata_d;
    logic [XLEN/8-1:0]   be_q, be_d;
    logic [XLEN-1:0]     instr_q, instr_d, dmrd_q, dmrd_d;
    logic                ic_rdy_q, ic_rdy_d, dm_rdy_q, dm_rdy_d;
    logic                err_q, err_d, err_src_q, err_src_d;

    logic            i_elig, d_elig, grant_i, grant_d, busy, done, timeout;
    logic [XLEN-1:0] rsp;

    always_comb begin
        // A requester whose ready pulse is out this cycle is still holding
        // its request line; mask it so the same request is not re-granted.
        i_elig  = i_IC_DataReq & ~ic_rdy_q;
        d_elig  = (i_DM_MemRead | i_DM_Wen) & ~dm_rdy_q;
        grant_i = (state_q == IDLE) & i_elig & (~d_elig | last_q);
        grant_d = (state_q == IDLE) & d_elig & ~grant_i;
        busy    = (state_q != IDLE);
        timeout = busy & ~i_MEM_ack & (cnt_q == TLIM);   // ack wins a tie
        done    = busy & (i_MEM_ack | timeout);
        rsp     = (i_MEM_ack && !we_q) ? i_MEM_rdata : '0;
    end

    // State / datapath registers
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            cnt_q     <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            instr_q   <= '0;
            ic_rdy_q  <= 1'b0;
            dmrd_q    <= '0;
            dm_rdy_q  <= 1'b0;
            err_q     <= 1'b0;
            err_src_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            instr_q   <= instr_d;
            ic_rdy_q  <= ic_rdy_d;
            dmrd_q    <= dmrd_d;
            dm_rdy_q  <= dm_rdy_d;
            err_q     <= err_d;
            err_src_q <= err_src_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_i) state_d = IBUSY;
                     else if (grant_d) state_d = DBUSY;
            IBUSY,
            DBUSY:   if (done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs and datapath
    always_comb begin
        last_d    = last_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        instr_d   = instr_q;
        dmrd_d    = dmrd_q;
        ic_rdy_d  = 1'b0;
        dm_rdy_d  = 1'b0;
        err_d     = 1'b0;
        err_src_d = err_src_q;

        if (grant_i) begin
            req_d   = 1'b1;
            we_d    = 1'b0;
            addr_d  = i_IM_Addr;
            wdata_d = '0;
            be_d    = '1;
            last_d  = 1'b0;
            cnt_d   = '0;
        end else if (grant_d) begin
            req_d   = 1'b1;
            we_d    = i_DM_Wen;
            addr_d  = i_DM_Addr;
            wdata_d = i_DM_Wd;
            be_d    = i_DM_Wen ? i_DM_byte_en : '1;
            last_d  = 1'b1;
            cnt_d   = '0;
        end else if (done) begin
            req_d = 1'b0;
            if (state_q == DBUSY) begin
                dmrd_d   = rsp;
                dm_rdy_d = 1'b1;
            end else begin
                instr_d  = rsp;
                ic_rdy_d = 1'b1;
            end
            if (timeout) begin
                err_d     = 1'b1;
                err_src_d = (state_q == DBUSY);
            end
        end else if (busy) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    assign o_MEM_req       = req_q;
    assign o_MEM_we        = we_q;
    assign o_MEM_addr      = addr_q;
    assign o_MEM_wdata     = wdata_q;
    assign o_MEM_byte_en   = be_q;
    assign o_IM_Instr      = instr_q;
    assign o_IC_MemReady   = ic_rdy_q;
    assign o_DM_ReadData   = dmrd_q;
    assign o_DM_data_ready = dm_rdy_q;
    assign o_bus_err       = err_q;
    assign o_bus_err_src   = err_src_q;
endmodule

// File: tb/tb_hart_mem_arbiter.sv
module tb_hart_mem_arbiter;
    localparam int TMO = 4;

    logic clk, rst_n;
    logic ic_req, dm_rd, dm_wen, mem_ack;
    logic [31:0] im_addr, dm_addr, dm_wd, mem_rdata;
    logic [3:0]  dm_be;
    logic [31:0] o_IM_Instr, o_DM_ReadData, o_MEM_addr, o_MEM_wdata;
    logic        o_IC_MemReady, o_DM_data_ready, o_MEM_req, o_MEM_we, o_bus_err, o_bus_err_src;
    logic [3:0]  o_MEM_byte_en;

    int checks = 0;
    int errors = 0;

    hart_mem_arbiter #(.XLEN(32), .TIMEOUT_CYCLES(TMO)) dut (
        .i_clk(clk), .i_rst(rst_n),
        .i_IC_DataReq(ic_req), .i_IM_Addr(im_addr),
        .o_IM_Instr(o_IM_Instr), .o_IC_MemReady(o_IC_MemReady),
        .i_DM_MemRead(dm_rd), .i_DM_Wen(dm_wen), .i_DM_Addr(dm_addr),
        .i_DM_Wd(dm_wd), .i_DM_byte_en(dm_be),
        .o_DM_ReadData(o_DM_ReadData), .o_DM_data_ready(o_DM_data_ready),
        .o_MEM_req(o_MEM_req), .o_MEM_we(o_MEM_we), .o_MEM_addr(o_MEM_addr),
        .o_MEM_wdata(o_MEM_wdata), .o_MEM_byte_en(o_MEM_byte_en),
        .i_MEM_ack(mem_ack), .i_MEM_rdata(mem_rdata),
        .o_bus_err(o_bus_err), .o_bus_err_src(o_bus_err_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          is_d;
        bit          rd;
        bit          wen;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  be;
        int          dly;      // edges after grant at which ack is given
        logic [31:0] rdata;
        bit          exp_we;
        logic [3:0]  exp_be;
        logic [31:0] exp_rd;
        bit          exp_err;
    } vec_t;
    vec_t tbl[8];

    // behavioural reference for the random phase
    bit          m_busy, m_isd, m_we, m_last_d, m_prdy_i, m_prdy_d;
    int          m_age;
    logic [31:0] m_addr, m_wd;
    logic [3:0]  m_be;
    bit          e_irdy, e_drdy, e_err, e_src;
    logic [31:0] e_idata, e_ddata;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        ic_req = 0; dm_rd = 0; dm_wen = 0; mem_ack = 0;
    endtask

    function automatic logic any_out();
        return |{o_IM_Instr, o_IC_MemReady, o_DM_ReadData, o_DM_data_ready, o_MEM_req,
                 o_MEM_we, o_MEM_addr, o_MEM_wdata, o_MEM_byte_en, o_bus_err, o_bus_err_src};
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        int lim;
        lim = (v.dly < TMO) ? v.dly : TMO;
        if (v.is_d) begin
            dm_rd = v.rd; dm_wen = v.wen; dm_addr = v.addr; dm_wd = v.wd; dm_be = v.be;
        end else begin
            ic_req = 1; im_addr = v.addr;
        end
        tick();
        clr_in();
        chk($sformatf("v%0d_req", idx), o_MEM_req, 1);
        chk($sformatf("v%0d_addr", idx), o_MEM_addr, v.addr);
        chk($sformatf("v%0d_we", idx), o_MEM_we, v.exp_we);
        chk($sformatf("v%0d_be", idx), o_MEM_byte_en, v.exp_be);
        if (v.exp_we) chk($sformatf("v%0d_wdata", idx), o_MEM_wdata, v.wd);
        for (int k = 1; k <= lim; k++) begin
            mem_ack = (k == v.dly); mem_rdata = v.rdata;
            tick();
            mem_ack = 0;
            if (k < lim) begin
                chk($sformatf("v%0d_hold_req", idx), o_MEM_req, 1);
                chk($sformatf("v%0d_hold_addr", idx), o_MEM_addr, v.addr);
                chk($sformatf("v%0d_early_rdy", idx), {o_IC_MemReady, o_DM_data_ready}, 0);
            end
        end
        chk($sformatf("v%0d_done_req", idx), o_MEM_req, 0);
        chk($sformatf("v%0d_irdy", idx), o_IC_MemReady, !v.is_d);
        chk($sformatf("v%0d_drdy", idx), o_DM_data_ready, v.is_d);
        chk($sformatf("v%0d_data", idx), v.is_d ? o_DM_ReadData : o_IM_Instr, v.exp_rd);
        chk($sformatf("v%0d_err", idx), o_bus_err, v.exp_err);
        if (v.exp_err) chk($sformatf("v%0d_src", idx), o_bus_err_src, v.is_d);
        tick();
        chk($sformatf("v%0d_pulse_end", idx), {o_IC_MemReady, o_DM_data_ready, o_bus_err}, 0);
    endtask

    task automatic model_step();
        bit ie, de, pick_d;
        logic [31:0] val;
        e_irdy = 0; e_drdy = 0; e_err = 0;
        if (m_busy) begin
            m_age++;
            if (mem_ack || m_age >= TMO) begin
                val = (mem_ack && !m_we) ? mem_rdata : 32'h0;
                if (m_isd) begin e_drdy = 1; e_ddata = val; end
                else begin e_irdy = 1; e_idata = val; end
                if (!mem_ack) begin e_err = 1; e_src = m_isd; end
                m_busy = 0;
            end
        end else begin
            ie = ic_req && !m_prdy_i;
            de = (dm_rd || dm_wen) && !m_prdy_d;
            if (ie || de) begin
                pick_d   = de && !(ie && m_last_d);
                m_isd    = pick_d;
                m_last_d = pick_d;
                m_we     = pick_d && dm_wen;
                m_addr   = pick_d ? dm_addr : im_addr;
                m_wd     = dm_wd;
                m_be     = m_we ? dm_be : 4'hF;
                m_busy   = 1;
                m_age    = 0;
            end
        end
        m_prdy_i = e_irdy;
        m_prdy_d = e_drdy;
    endtask

    initial begin
        //            is_d rd wen addr          wd            be    dly rdata         we  ebe   exp_rd        err
        tbl[0] = '{1'b0, 0, 0, 32'h100,      32'h0,        4'h0, 3,  32'h00000013, 0, 4'hF, 32'h00000013, 0};
        tbl[1] = '{1'b1, 1, 0, 32'h40,       32'h0,        4'h3, 1,  32'hCAFEF00D, 0, 4'hF, 32'hCAFEF00D, 0};
        tbl[2] = '{1'b1, 0, 1, 32'h20,       32'hDEADBEEF, 4'h3, 2,  32'h00000055, 1, 4'h3, 32'h0,        0};
        tbl[3] = '{1'b1, 1, 0, 32'h80,       32'h0,        4'h0, 99, 32'h11111111, 0, 4'hF, 32'h0,        1};
        tbl[4] = '{1'b0, 0, 0, 32'h104,      32'h0,        4'h0, 99, 32'h22222222, 0, 4'hF, 32'h0,        1};
        tbl[5] = '{1'b1, 1, 0, 32'h44,       32'h0,        4'h0, 4,  32'h12345678, 0, 4'hF, 32'h12345678, 0};
        tbl[6] = '{1'b1, 1, 1, 32'h28,       32'h11223344, 4'hC, 1,  32'h99999999, 1, 4'hC, 32'h0,        0};
        tbl[7] = '{1'b0, 0, 0, 32'hFFFFFFFC, 32'h0,        4'h0, 1,  32'h87654321, 0, 4'hF, 32'h87654321, 0};

        clr_in();
        im_addr = 0; dm_addr = 0; dm_wd = 0; dm_be = 0; mem_rdata = 0;
        rst_n = 0;
        #12;
        chk("reset_outputs", any_out(), 0);
        rst_n = 1;
        tick();

        // contention right after reset: fetch first, then the write
        ic_req = 1; im_addr = 32'h0;
        dm_wen = 1; dm_addr = 32'h20; dm_wd = 32'hDEADBEEF; dm_be = 4'h3;
        tick();
        chk("cont_first_req", o_MEM_req, 1);
        chk("cont_first_addr", o_MEM_addr, 32'h0);
        chk("cont_first_we", o_MEM_we, 0);
        mem_ack = 1; mem_rdata = 32'h13;
        tick();
        mem_ack = 0;
        chk("cont_irdy", o_IC_MemReady, 1);
        chk("cont_idata", o_IM_Instr, 32'h13);
        ic_req = 0;
        tick();
        chk("cont_second_req", o_MEM_req, 1);
        chk("cont_second_addr", o_MEM_addr, 32'h20);
        chk("cont_second_we", o_MEM_we, 1);
        chk("cont_second_wdata", o_MEM_wdata, 32'hDEADBEEF);
        chk("cont_second_be", o_MEM_byte_en, 4'h3);
        mem_ack = 1; mem_rdata = 32'h77;
        tick();
        clr_in();
        chk("cont_drdy", o_DM_data_ready, 1);
        chk("cont_ddata", o_DM_ReadData, 0);
        tick();

        // both held continuously: strict alternation I, D, I, D, I, D
        ic_req = 1; im_addr = 32'h200; dm_rd = 1; dm_addr = 32'h300;
        for (int n = 0; n < 6; n++) begin
            tick();
            chk($sformatf("alt%0d_req", n), o_MEM_req, 1);
            chk($sformatf("alt%0d_addr", n), o_MEM_addr, (n % 2 == 0) ? 32'h200 : 32'h300);
            mem_ack = 1; mem_rdata = 32'(n + 1);
            tick();
            mem_ack = 0;
            chk($sformatf("alt%0d_irdy", n), o_IC_MemReady, (n % 2 == 0));
            chk($sformatf("alt%0d_drdy", n), o_DM_data_ready, (n % 2 == 1));
            chk($sformatf("alt%0d_data", n), (n % 2 == 0) ? o_IM_Instr : o_DM_ReadData, n + 1);
        end
        clr_in();
        tick();

        // table-driven single transactions
        for (int i = 0; i < 8; i++) run_vec(tbl[i], i);

        // reset while DBUSY
        dm_rd = 1; dm_addr = 32'h60;
        tick();
        clr_in();
        chk("rstbusy_req", o_MEM_req, 1);
        #2 rst_n = 0;
        #1;
        chk("rstbusy_async_outputs", any_out(), 0);
        mem_ack = 1;
        tick();
        mem_ack = 0;
        chk("rstbusy_held_outputs", any_out(), 0);
        #2 rst_n = 1;
        ic_req = 1; im_addr = 32'h300; dm_rd = 1; dm_addr = 32'h340;
        tick();
        chk("rstbusy_fetch_wins", o_MEM_addr, 32'h300);
        chk("rstbusy_fetch_req", o_MEM_req, 1);
        clr_in();
        mem_ack = 1; mem_rdata = 32'hABCD;
        tick();
        mem_ack = 0;
        chk("rstbusy_irdy", o_IC_MemReady, 1);
        chk("rstbusy_idata", o_IM_Instr, 32'hABCD);
        tick();

        // random traffic against the reference model, from a fresh reset
        #1 rst_n = 0;
        #2 rst_n = 1;
        m_busy = 0; m_last_d = 1; m_prdy_i = 0; m_prdy_d = 0; m_age = 0;
        e_idata = 0; e_ddata = 0; e_src = 0;
        for (int c = 0; c < 2000; c++) begin
            ic_req    = $urandom_range(0, 1);
            dm_rd     = ($urandom_range(0, 3) == 0);
            dm_wen    = ($urandom_range(0, 3) == 0);
            im_addr   = $urandom;
            dm_addr   = $urandom;
            dm_wd     = $urandom;
            dm_be     = 4'($urandom_range(0, 15));
            mem_ack   = ($urandom_range(0, 9) < 3);
            mem_rdata = $urandom;
            model_step();
            tick();
            chk($sformatf("rnd%0d_req", c), o_MEM_req, m_busy);
            if (m_busy) begin
                chk($sformatf("rnd%0d_addr", c), o_MEM_addr, m_addr);
                chk($sformatf("rnd%0d_we", c), o_MEM_we, m_we);
                chk($sformatf("rnd%0d_be", c), o_MEM_byte_en, m_be);
                if (m_we) chk($sformatf("rnd%0d_wdata", c), o_MEM_wdata, m_wd);
            end
            chk($sformatf("rnd%0d_rdy", c), {o_IC_MemReady, o_DM_data_ready, o_bus_err},
                {e_irdy, e_drdy, e_err});
            if (e_irdy) chk($sformatf("rnd%0d_idata", c), o_IM_Instr, e_idata);
            if (e_drdy) chk($sformatf("rnd%0d_ddata", c), o_DM_ReadData, e_ddata);
            if (e_err)  chk($sformatf("rnd%0d_src", c), o_bus_err_src, e_src);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
